// File: rtl/ct_idu_rf_prf_gated_preg_mp.sv
// Physical register file entry with its own allocate/writeback/release FSM.
// The data register and the control flops sit on separate gated copies of
// forever_cpuclk so an idle entry burns no clock power.
// Build option: define CT_IDU_PREG_WB_CHK_EN to add the sticky writeback
// protocol checker (x_wb_err); otherwise x_wb_err is tied low.

// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock cannot glitch.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic clk_en_d;
  logic clk_en_q;

  assign clk_en_d = (global_en & (module_en | local_en)) | external_en;

  // Transparent-low enable latch.
  always_latch begin
    if (!clk_in) clk_en_q <= clk_en_d;
  end

  assign clk_out = clk_in & (clk_en_q | pad_yy_icg_scan_en);
endmodule

// state | meaning
// FREE  | entry not owned by any rename mapping
// ALLOC | allocated by rename, value not yet written back
// READY | allocated and holding a written-back value
module ct_idu_rf_prf_gated_preg_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int WB_PORTS   = 3
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst,
  input  logic                           cp0_yy_clk_en,
  input  logic                           cp0_idu_icg_en,
  input  logic                           pad_yy_icg_scan_en,
  input  logic                           x_alloc_vld,
  input  logic                           x_dealloc_vld,
  input  logic [WB_PORTS-1:0]            x_wb_vld,
  input  logic [WB_PORTS*DATA_WIDTH-1:0] x_wb_data,
  output logic [DATA_WIDTH-1:0]          x_reg_dout,
  output logic [DATA_WIDTH-1:0]          x_bypass_dout,
  output logic                           x_rdy,
  output logic                           x_busy,
  output logic                           x_wb_err
);
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ALLOC = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    rdy_q, busy_q;
  logic [DATA_WIDTH-1:0]   reg_q;
  logic [DATA_WIDTH-1:0]   wb_sel_data;
  logic                    wb_any;
  logic                    data_local_en;
  logic                    ctrl_local_en;
  logic                    data_clk;
  logic                    ctrl_clk;

  assign wb_any = |x_wb_vld;

  // Writeback mux: lowest-index valid port wins.
  always_comb begin
    wb_sel_data = '0;
    for (int i = WB_PORTS - 1; i >= 0; i--) begin
      if (x_wb_vld[i]) wb_sel_data = x_wb_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // cpurst is part of both enables so reset always reaches the gated flops.
  assign data_local_en = wb_any | cpurst;
  assign ctrl_local_en = x_alloc_vld | x_dealloc_vld | wb_any | cpurst;

  gated_clk_cell u_data_gcc (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_idu_icg_en),
    .local_en           (data_local_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (data_clk)
  );

  gated_clk_cell u_ctrl_gcc (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_idu_icg_en),
    .local_en           (ctrl_local_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (ctrl_clk)
  );

  // Data register: capture selected writeback data in any state.
  always_ff @(posedge data_clk) begin
    if (cpurst)      reg_q <= '0;
    else if (wb_any) reg_q <= wb_sel_data;
  end

  // Next-state: alloc wins only from FREE or when paired with dealloc;
  // otherwise an alloc to a live entry leaves it untouched.
  always_comb begin
    state_d = state_q;
    if (x_alloc_vld) begin
      if (state_q == FREE || x_dealloc_vld) state_d = ALLOC;
    end else begin
      case (state_q)
        ALLOC: begin
          if (x_dealloc_vld) state_d = FREE;
          else if (wb_any)   state_d = READY;
        end
        READY: if (x_dealloc_vld) state_d = FREE;
        default: state_d = state_q;
      endcase
    end
  end

  // State register with registered status outputs.
  always_ff @(posedge ctrl_clk) begin
    if (cpurst) begin
      state_q <= FREE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == READY);
      busy_q  <= (state_d == ALLOC) || (state_d == READY);
    end
  end

`ifdef CT_IDU_PREG_WB_CHK_EN
  logic wb_err_q;
  logic wb_err_set;

  assign wb_err_set = ($countones(x_wb_vld) > 1)
                    | (wb_any & (state_q == FREE) & ~x_alloc_vld)
                    | (wb_any & (state_q == READY));

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge ctrl_clk) begin
    if (cpurst)          wb_err_q <= 1'b0;
    else if (wb_err_set) wb_err_q <= 1'b1;
  end

  assign x_wb_err = wb_err_q;
`else
  assign x_wb_err = 1'b0;
`endif

  assign x_reg_dout    = reg_q;
  assign x_bypass_dout = wb_any ? wb_sel_data : reg_q;
  assign x_rdy         = rdy_q;
  assign x_busy        = busy_q;
endmodule

// File: tb/tb_ct_idu_rf_prf_gated_preg_mp.sv
// Directed bench for ct_idu_rf_prf_gated_preg_mp: default 64x3 instance plus
// a 32x5 instance for the wide-port case. Inputs change 1 ns after the rising
// edge; outputs are checked before the next rising edge.
module tb_ct_idu_rf_prf_gated_preg_mp;
`ifdef CT_IDU_PREG_WB_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         cpurst, clk_en, icg_en, scan_en;
  logic         alloc, dealloc;
  logic [2:0]   wb_vld;
  logic [191:0] wb_data;
  logic [63:0]  reg_dout, byp;
  logic         rdy, busy, err;

  logic         w_alloc, w_dealloc;
  logic [4:0]   w_wb_vld;
  logic [159:0] w_wb_data;
  logic [31:0]  w_reg, w_byp;
  logic         w_rdy, w_busy, w_err;

  int n_vec = 0;
  int n_err = 0;

  ct_idu_rf_prf_gated_preg_mp dut (
    .forever_cpuclk(clk), .cpurst(cpurst), .cp0_yy_clk_en(clk_en),
    .cp0_idu_icg_en(icg_en), .pad_yy_icg_scan_en(scan_en),
    .x_alloc_vld(alloc), .x_dealloc_vld(dealloc), .x_wb_vld(wb_vld),
    .x_wb_data(wb_data), .x_reg_dout(reg_dout), .x_bypass_dout(byp),
    .x_rdy(rdy), .x_busy(busy), .x_wb_err(err)
  );

  ct_idu_rf_prf_gated_preg_mp #(.DATA_WIDTH(32), .WB_PORTS(5)) u_wide (
    .forever_cpuclk(clk), .cpurst(cpurst), .cp0_yy_clk_en(clk_en),
    .cp0_idu_icg_en(icg_en), .pad_yy_icg_scan_en(scan_en),
    .x_alloc_vld(w_alloc), .x_dealloc_vld(w_dealloc), .x_wb_vld(w_wb_vld),
    .x_wb_data(w_wb_data), .x_reg_dout(w_reg), .x_bypass_dout(w_byp),
    .x_rdy(w_rdy), .x_busy(w_busy), .x_wb_err(w_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    alloc = 1'b0; dealloc = 1'b0; wb_vld = '0; wb_data = '0;
    #1;
  endtask

  task automatic test_reset();
    cpurst = 1'b1; clk_en = 1'b1; icg_en = 1'b0; scan_en = 1'b0;
    alloc = 1'b0; dealloc = 1'b0; wb_vld = '0; wb_data = '0;
    w_alloc = 1'b0; w_dealloc = 1'b0; w_wb_vld = '0; w_wb_data = '0;
    tick(); tick();
    n_vec++; if (reg_dout !== 64'h0) begin n_err++; $display("FAIL rst_reg got %0h exp 0", reg_dout); end
    n_vec++; if (byp !== 64'h0) begin n_err++; $display("FAIL rst_byp got %0h exp 0", byp); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy got %0b exp 0", rdy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b exp 0", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %0b exp 0", err); end
    n_vec++; if (w_reg !== 32'h0) begin n_err++; $display("FAIL rst_wide_reg got %0h exp 0", w_reg); end
    cpurst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_post_busy got %0b exp 0", busy); end
  endtask

  task automatic test_alloc_write();
    alloc = 1'b1; tick(); clr();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL aw_busy got %0b exp 1", busy); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL aw_rdy0 got %0b exp 0", rdy); end
    wb_vld = 3'b010;
    wb_data[0 +: 64] = 64'h11; wb_data[64 +: 64] = 64'hA5; wb_data[128 +: 64] = 64'h22;
    #1;
    n_vec++; if (byp !== 64'hA5) begin n_err++; $display("FAIL aw_byp got %0h exp a5", byp); end
    n_vec++; if (reg_dout !== 64'h0) begin n_err++; $display("FAIL aw_reg_pre got %0h exp 0", reg_dout); end
    tick(); clr();
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL aw_rdy got %0b exp 1", rdy); end
    n_vec++; if (reg_dout !== 64'hA5) begin n_err++; $display("FAIL aw_reg got %0h exp a5", reg_dout); end
    n_vec++; if (byp !== 64'hA5) begin n_err++; $display("FAIL aw_byp_idle got %0h exp a5", byp); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL aw_err got %0b exp 0", err); end
  endtask

  task automatic test_multi_write();
    dealloc = 1'b1; tick(); clr();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mw_free_busy got %0b exp 0", busy); end
    alloc = 1'b1; tick(); clr();
    wb_vld = 3'b101;
    wb_data[0 +: 64] = 64'h1234; wb_data[64 +: 64] = 64'hFFFF; wb_data[128 +: 64] = 64'h5678;
    #1;
    n_vec++; if (byp !== 64'h1234) begin n_err++; $display("FAIL mw_byp got %0h exp 1234", byp); end
    tick(); clr();
    n_vec++; if (reg_dout !== 64'h1234) begin n_err++; $display("FAIL mw_reg got %0h exp 1234", reg_dout); end
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL mw_rdy got %0b exp 1", rdy); end
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL mw_err got %0b exp %0b", err, CHK); end
  endtask

  task automatic test_alloc_dealloc();
    alloc = 1'b1; dealloc = 1'b1; tick(); clr();
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL ad_rdy got %0b exp 0", rdy); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ad_busy got %0b exp 1", busy); end
  endtask

  task automatic test_reset_wb();
    cpurst = 1'b1; wb_vld = 3'b001; wb_data[0 +: 64] = 64'h77;
    tick(); cpurst = 1'b0; clr();
    n_vec++; if (reg_dout !== 64'h0) begin n_err++; $display("FAIL rw_reg got %0h exp 0", reg_dout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rw_busy got %0b exp 0", busy); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rw_rdy got %0b exp 0", rdy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rw_err got %0b exp 0", err); end
  endtask

  task automatic test_ignore();
    dealloc = 1'b1; tick(); clr();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ig_dealloc_free got %0b exp 0", busy); end
    alloc = 1'b1; wb_vld = 3'b001; wb_data[0 +: 64] = 64'h3C; tick(); clr();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ig_aw_busy got %0b exp 1", busy); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL ig_aw_rdy got %0b exp 0", rdy); end
    n_vec++; if (reg_dout !== 64'h3C) begin n_err++; $display("FAIL ig_aw_reg got %0h exp 3c", reg_dout); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ig_aw_err got %0b exp 0", err); end
    wb_vld = 3'b100; wb_data[128 +: 64] = 64'h5A; tick(); clr();
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL ig_w_rdy got %0b exp 1", rdy); end
    n_vec++; if (reg_dout !== 64'h5A) begin n_err++; $display("FAIL ig_w_reg got %0h exp 5a", reg_dout); end
    alloc = 1'b1; tick(); clr();
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL ig_alloc_ready got %0b exp 1", rdy); end
    wb_vld = 3'b001; wb_data[0 +: 64] = 64'h66; tick(); clr();
    n_vec++; if (reg_dout !== 64'h66) begin n_err++; $display("FAIL ig_rw_reg got %0h exp 66", reg_dout); end
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL ig_rw_rdy got %0b exp 1", rdy); end
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL ig_rw_err got %0b exp %0b", err, CHK); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (dut.data_local_en !== 1'b0) begin n_err++; $display("FAIL idle_data_en cyc %0d got %0b exp 0", i, dut.data_local_en); end
      n_vec++; if (dut.ctrl_local_en !== 1'b0) begin n_err++; $display("FAIL idle_ctrl_en cyc %0d got %0b exp 0", i, dut.ctrl_local_en); end
      n_vec++; if (reg_dout !== 64'h66) begin n_err++; $display("FAIL idle_reg cyc %0d got %0h exp 66", i, reg_dout); end
      n_vec++; if (err !== CHK) begin n_err++; $display("FAIL idle_err cyc %0d got %0b exp %0b", i, err, CHK); end
    end
    cpurst = 1'b1; tick(); cpurst = 1'b0; clr();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL idle_rst_err got %0b exp 0", err); end
  endtask

  task automatic test_free_write();
    wb_vld = 3'b010; wb_data[64 +: 64] = 64'h99; tick(); clr();
    n_vec++; if (reg_dout !== 64'h99) begin n_err++; $display("FAIL fw_reg got %0h exp 99", reg_dout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fw_busy got %0b exp 0", busy); end
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL fw_err got %0b exp %0b", err, CHK); end
  endtask

  task automatic test_wide();
    w_alloc = 1'b1; tick(); w_alloc = 1'b0;
    w_wb_vld = 5'b10000;
    w_wb_data[0 +: 32] = 32'h1; w_wb_data[32 +: 32] = 32'h2; w_wb_data[64 +: 32] = 32'h3;
    w_wb_data[96 +: 32] = 32'h4; w_wb_data[128 +: 32] = 32'hDEADBEEF;
    #1;
    n_vec++; if (w_byp !== 32'hDEADBEEF) begin n_err++; $display("FAIL wide_byp got %0h exp deadbeef", w_byp); end
    tick(); w_wb_vld = '0; #1;
    n_vec++; if (w_reg !== 32'hDEADBEEF) begin n_err++; $display("FAIL wide_reg got %0h exp deadbeef", w_reg); end
    n_vec++; if (w_rdy !== 1'b1) begin n_err++; $display("FAIL wide_rdy got %0b exp 1", w_rdy); end
    w_wb_vld = 5'b11000; w_wb_data[96 +: 32] = 32'hCAFEF00D; w_wb_data[128 +: 32] = 32'h12345678;
    tick(); w_wb_vld = '0; #1;
    n_vec++; if (w_reg !== 32'hCAFEF00D) begin n_err++; $display("FAIL wide_prio_reg got %0h exp cafef00d", w_reg); end
    n_vec++; if (w_err !== CHK) begin n_err++; $display("FAIL wide_err got %0b exp %0b", w_err, CHK); end
  endtask

  initial begin
    test_reset();
    test_alloc_write();
    test_multi_write();
    test_alloc_dealloc();
    test_reset_wb();
    test_ignore();
    test_idle();
    test_free_write();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
